freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//  Measures the frequency of an asynchronous square wave sig_in, e.g. the slow clock from the divider.
//  Counts rising edges over a fixed gate window of GATE_CYCLES clock_in cycles.
//  Publishes the count once per window with a 1-cycle valid strobe.
//  Used on-board to check divider outputs and external signals, and to drive the display logic.
// PARAMETERS
//  GATE_CYCLES  50_000_000  gate window length in clock_in cycles (1 s at 50 MHz); must be >= 2
//  CNT_BITS     26          width of the edge counter and of freq_out
//  SYNC_STAGES  2           synchronizer flops on sig_in; must be >= 2
// PORTS
//  clock_in   in   1         system clock
//  reset_n    in   1         asynchronous, active-low reset
//  enable     in   1         1 = measure continuously; 0 = stop and return to IDLE
//  sig_in     in   1         asynchronous signal to measure
//  freq_out   out  CNT_BITS  rising edges counted in the last completed window
//  valid      out  1         1-cycle pulse; freq_out/overflow updated on the same cycle
//  overflow   out  1         last published window saturated the edge counter
//  busy       out  1         1 while in SETTLE or GATE
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - freq_out=0, valid=0, overflow=0, busy=0.
//   - Sync chain, counters and FSM cleared; state=IDLE.
//  Edge detect:
//   - sig_in passes through SYNC_STAGES flops.
//   - edge=1 for one cycle when the synced value goes 0->1.
//   - Latency: SYNC_STAGES+1 clock_in cycles from sig_in rise to edge.
//  FSM states:
//   - IDLE:   counters held at 0. enable=1 -> SETTLE.
//   - SETTLE: lasts SYNC_STAGES+1 cycles to flush stale sync data; edges are ignored. Then -> GATE.
//   - GATE:   gate_cnt counts 0..GATE_CYCLES-1. edge_cnt += edge, saturating at 2^CNT_BITS-1.
//  Gate counter width: $clog2(GATE_CYCLES).
//  End of window (GATE and gate_cnt==GATE_CYCLES-1):
//   - freq_out <= sat(edge_cnt+edge); overflow <= saturation occurred in this window.
//   - valid <= 1 for exactly 1 cycle.
//   - gate_cnt <= 0 and edge_cnt <= 0; state stays GATE, so windows are back to back with no lost cycles.
//  Simultaneous events:
//   - An edge on the last window cycle counts in the closing window.
//   - An edge on the first cycle of the next window counts in the new window.
//  enable=0 in any state:
//   - Next state is IDLE; the current window is discarded and no valid is produced.
//   - freq_out/overflow hold their last published values; busy=0 from the next cycle.
//  Saturation: edge_cnt sticks at all-ones; overflow is set only at publish and is recomputed each window.
//  Reset mid-window: immediate clear as above; no valid pulse.
//  valid is never asserted on two consecutive cycles, since GATE_CYCLES >= 2.
// STRUCTURE
//  - freq_meter_pkg: state typedef (IDLE, SETTLE, GATE) and the localparam sizing helpers.
//  - Sub-module edge_sync (params SYNC_STAGES; ports clock_in, reset_n, d_async, rise):
//    synchronizer plus rising-edge detector, reusable for buttons and other async inputs.
//  - Top level: FSM, gate counter, saturating edge counter, output registers.
// TESTING (GATE_CYCLES=100, SYNC_STAGES=2 unless stated)
//  1. reset_n=0 mid-run -> freq_out=0, valid=0, overflow=0, busy=0 immediately; IDLE after release.
//  2. sig_in period 10 cycles, enable=1 -> valid every 100 cycles; freq_out=10 from the 2nd window on; overflow=0.
//  3. sig_in held 0, then held 1 -> freq_out=0 each window; the single 0->1 transition is counted once.
//  4. CNT_BITS=4, sig_in period 2 (50 edges/window) -> freq_out=15, overflow=1;
//     then period 10 -> freq_out=10, overflow=0.
//  5. enable dropped at window cycle 50 -> no valid, freq_out holds 10, busy=0 next cycle;
//     re-enable -> busy=1, first valid 3+100 cycles later.
//  6. Edge timed so that edge=1 on gate_cnt==99 -> counted in the closing window;
//     edge on gate_cnt==0 -> counted in the new window.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and sizing helpers for the gated edge-counting frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE} state_t;

    localparam int DEF_GATE_CYCLES = 50_000_000;
    localparam int DEF_CNT_BITS    = 26;
    localparam int DEF_SYNC_STAGES = 2;

    // Counter width for a counter running 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Multi-flop synchronizer with a registered rising-edge pulse; rise lands
// SYNC_STAGES+1 clocks after the asynchronous input goes high.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic d_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d_async};
            prev <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over back-to-back gate windows
// of GATE_CYCLES clocks and publishes each count with a one-cycle valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_BITS    = DEF_CNT_BITS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                sig_in,
    output logic [CNT_BITS-1:0] freq_out,
    output logic                valid,
    output logic                overflow,
    output logic                busy
);

    localparam int GW = cnt_width(GATE_CYCLES);
    localparam int SW = cnt_width(SYNC_STAGES + 1);
    localparam logic [GW-1:0]       GATE_LAST   = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0]       SETTLE_LAST = SW'(SYNC_STAGES);
    localparam logic [CNT_BITS-1:0] CNT_MAX     = '1;

    state_t              state, state_nxt;
    logic [GW-1:0]       gate_cnt;
    logic [SW-1:0]       settle_cnt;
    logic [CNT_BITS-1:0] edge_cnt, edge_sum;
    logic                sat_seen, edge_drop, edge_rise, window_end;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .d_async  (sig_in),
        .rise     (edge_rise)
    );

    // Overflow means an edge was actually dropped, not merely that the count hit all-ones.
    assign edge_drop  = edge_rise && (edge_cnt == CNT_MAX);
    assign edge_sum   = edge_drop ? CNT_MAX : edge_cnt + CNT_BITS'(edge_rise);
    assign window_end = enable && (state == GATE) && (gate_cnt == GATE_LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SETTLE;
                SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = GATE;
                GATE:    state_nxt = GATE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            gate_cnt   <= '0;
            settle_cnt <= '0;
            edge_cnt   <= '0;
            sat_seen   <= 1'b0;
        end else if (!enable || state == IDLE) begin
            gate_cnt   <= '0;
            settle_cnt <= '0;
            edge_cnt   <= '0;
            sat_seen   <= 1'b0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + SW'(1);
        end else if (window_end) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_seen <= 1'b0;
        end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_sum;
            sat_seen <= sat_seen | edge_drop;
        end
    end

    // Published results hold across disable; only reset clears them.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            freq_out <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= window_end;
            if (window_end) begin
                freq_out <= edge_sum;
                overflow <= sat_seen | edge_drop;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: window timing, counting, saturation, enable and reset.
module tb_freq_meter;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic        sig_in   = 1'b0;
    logic [25:0] freq_out;
    logic        valid, overflow, busy;
    logic [3:0]  freq4_out;
    logic        valid4, overflow4, busy4;

    int checks = 0;
    int passes = 0;

    int period     = 0;
    bit hold_lvl   = 1'b0;
    bit manual     = 1'b0;
    bit manual_lvl = 1'b0;
    int phase      = 0;

    freq_meter #(.GATE_CYCLES(100), .CNT_BITS(26), .SYNC_STAGES(2)) dut (
        .clock_in (clock_in), .reset_n (reset_n), .enable (enable), .sig_in (sig_in),
        .freq_out (freq_out), .valid (valid), .overflow (overflow), .busy (busy)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_BITS(4), .SYNC_STAGES(2)) dut4 (
        .clock_in (clock_in), .reset_n (reset_n), .enable (enable), .sig_in (sig_in),
        .freq_out (freq4_out), .valid (valid4), .overflow (overflow4), .busy (busy4)
    );

    initial forever #5 clock_in = ~clock_in;

    // sig_in changes only on falling edges: periodic, held level, or manual level
    initial forever begin
        @(negedge clock_in);
        if (manual)           sig_in = manual_lvl;
        else if (period == 0) sig_in = hold_lvl;
        else begin
            phase  = (phase + 1) % period;
            sig_in = (phase < period / 2);
        end
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock_in); #1;
            if (valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++;
            $display("FAIL valid_timeout: no valid within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0;
        repeat (3) @(posedge clock_in); #1;
        checks++; if (freq_out !== 26'd0) $display("FAIL rst_freq got %0d exp 0", freq_out); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", overflow); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passes++;
        @(negedge clock_in); reset_n = 1'b1;
        repeat (3) @(posedge clock_in); #1;
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy); else passes++;
    endtask

    task automatic test_periodic();
        bit ok;
        int n;
        period = 10;
        enable = 1'b1;
        wait_valid(400, ok);
        @(posedge clock_in); #1;
        checks++; if (valid !== 1'b0) $display("FAIL valid_width got %b exp 0", valid); else passes++;
        n = 1;
        while (!valid && n < 300) begin @(posedge clock_in); #1; n++; end
        checks++; if (n !== 100) $display("FAIL valid_interval got %0d exp 100", n); else passes++;
        checks++; if (freq_out !== 26'd10) $display("FAIL per10_freq got %0d exp 10", freq_out); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL per10_ovf got %b exp 0", overflow); else passes++;
        wait_valid(200, ok);
        checks++; if (freq_out !== 26'd10) $display("FAIL per10_freq3 got %0d exp 10", freq_out); else passes++;
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit seen;
        int n;
        wait_valid(200, ok);
        repeat (50) @(posedge clock_in); #1;
        checks++; if (busy !== 1'b1) $display("FAIL drop_busy_before got %b exp 1", busy); else passes++;
        enable = 1'b0;
        @(posedge clock_in); #1;
        checks++; if (busy !== 1'b0) $display("FAIL drop_busy_after got %b exp 0", busy); else passes++;
        seen = 1'b0;
        repeat (200) begin @(posedge clock_in); #1; if (valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) $display("FAIL drop_no_valid got %b exp 0", seen); else passes++;
        checks++; if (freq_out !== 26'd10) $display("FAIL drop_hold got %0d exp 10", freq_out); else passes++;
        enable = 1'b1;
        n = 0;
        do begin
            @(posedge clock_in); #1; n++;
            if (n == 1) begin
                checks++; if (busy !== 1'b1) $display("FAIL reen_busy got %b exp 1", busy); else passes++;
            end
        end while (!valid && n < 400);
        checks++; if (n !== 104) $display("FAIL reen_latency got %0d exp 104", n); else passes++;
        checks++; if (freq_out !== 26'd10) $display("FAIL reen_freq got %0d exp 10", freq_out); else passes++;
    endtask

    task automatic test_window_edge();
        bit ok;
        manual_lvl = 1'b0; manual = 1'b1;
        wait_valid(200, ok);
        wait_valid(200, ok);
        // rise reaches the counter on the closing window's last cycle
        repeat (96) @(posedge clock_in); #1;
        manual_lvl = 1'b1;
        wait_valid(200, ok);
        checks++; if (freq_out !== 26'd1) $display("FAIL edge_last got %0d exp 1", freq_out); else passes++;
        manual_lvl = 1'b0;
        // rise reaches the counter on the new window's first cycle
        repeat (97) @(posedge clock_in); #1;
        manual_lvl = 1'b1;
        wait_valid(200, ok);
        checks++; if (freq_out !== 26'd0) $display("FAIL edge_first_old got %0d exp 0", freq_out); else passes++;
        wait_valid(200, ok);
        checks++; if (freq_out !== 26'd1) $display("FAIL edge_first_new got %0d exp 1", freq_out); else passes++;
    endtask

    task automatic test_static();
        bit ok;
        hold_lvl = 1'b0; period = 0; manual = 1'b0;
        wait_valid(200, ok);
        wait_valid(200, ok);
        checks++; if (freq_out !== 26'd0) $display("FAIL hold0 got %0d exp 0", freq_out); else passes++;
        hold_lvl = 1'b1;
        wait_valid(200, ok);
        checks++; if (freq_out !== 26'd1) $display("FAIL step01 got %0d exp 1", freq_out); else passes++;
        wait_valid(200, ok);
        checks++; if (freq_out !== 26'd0) $display("FAIL hold1 got %0d exp 0", freq_out); else passes++;
    endtask

    task automatic test_overflow();
        bit ok;
        period = 2;
        wait_valid(200, ok);
        wait_valid(200, ok);
        checks++; if (valid4 !== 1'b1) $display("FAIL sat_valid4 got %b exp 1", valid4); else passes++;
        checks++; if (freq4_out !== 4'd15) $display("FAIL sat_freq got %0d exp 15", freq4_out); else passes++;
        checks++; if (overflow4 !== 1'b1) $display("FAIL sat_ovf got %b exp 1", overflow4); else passes++;
        checks++; if (freq_out !== 26'd50) $display("FAIL wide_freq got %0d exp 50", freq_out); else passes++;
        period = 10;
        wait_valid(200, ok);
        wait_valid(200, ok);
        checks++; if (freq4_out !== 4'd10) $display("FAIL unsat_freq got %0d exp 10", freq4_out); else passes++;
        checks++; if (overflow4 !== 1'b0) $display("FAIL unsat_ovf got %b exp 0", overflow4); else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        wait_valid(200, ok);
        checks++; if (freq_out !== 26'd10) $display("FAIL pre_rst_freq got %0d exp 10", freq_out); else passes++;
        repeat (30) @(posedge clock_in); #1;
        reset_n = 1'b0; #1;
        checks++; if (freq_out !== 26'd0) $display("FAIL mid_rst_freq got %0d exp 0", freq_out); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", busy); else passes++;
        checks++; if (valid !== 1'b0 || overflow !== 1'b0) $display("FAIL mid_rst_flags got %b%b exp 00", valid, overflow); else passes++;
        enable = 1'b0;
        @(negedge clock_in); reset_n = 1'b1;
        seen = 1'b0;
        repeat (150) begin @(posedge clock_in); #1; if (valid || busy) seen = 1'b1; end
        checks++; if (seen !== 1'b0) $display("FAIL post_rst_idle got %b exp 0", seen); else passes++;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_enable_drop();
        test_window_edge();
        test_static();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
